traffic_light_monitor: RTL and testbench
========================================

# traffic_light_monitor

- Observing end of the two-direction lamp interface; samples the six lamp lines (`ledr1/ledb1/ledg1`, `ledr2/ledb2/ledg2`) as asynchronous inputs.
- Filters glitches, decodes the current intersection phase and measures how long each phase is held, in clock cycles.
- Raises sticky safety flags for conflicting or illegal lamp patterns.
- Used in-fabric as a checker beside the lamp driver and as the receive side when lamp lines come from an external board.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer flops per lamp input (≥2).
- `STABLE_CYCLES`, 4: consecutive identical synchronized samples required before a lamp vector is accepted (≥1).
- `CNT_W`, 28: duration counter width.
- `MAX_PHASE_CYCLES`, 28'd125000000: stuck-phase threshold in cycles.

Ports:
- `clk` in 1: single clock. All logic is in this domain.
- `rst` in 1: reset, asynchronous assert, active-low.
- `ledr1`, `ledb1`, `ledg1` in 1 each: direction-1 red, amber, green. Asynchronous.
- `ledr2`, `ledb2`, `ledg2` in 1 each: direction-2 red, amber, green. Asynchronous.
- `clr_err` in 1: synchronous clear of the sticky flags.
- `phase` out 3: decoded accepted phase.
- `dur` out CNT_W: duration of the phase that just ended.
- `dur_valid` out 1: one-cycle strobe qualifying `dur`.
- `conflict` out 1: sticky, both directions non-red.
- `fault` out 1: sticky, illegal or dark lamp pattern.
- `stuck` out 1: sticky, phase held too long.

## Operation
- Sync: each of the 6 inputs passes through its own `SYNC_STAGES` flop chain. This gives the synchronized vector `s[5:0]`.
- Filter:
  - The candidate register `cand` tracks `s`. The stability counter `stab` resets to 1 whenever `s != cand`; otherwise it increments, saturating at `STABLE_CYCLES`.
  - The accepted vector `acc` loads `cand` in the cycle `stab` reaches `STABLE_CYCLES`.
- Per-direction decode of (r,b,g): 100 RED, 010 AMBER, 001 GREEN, 110 RED_AMBER. Any other pattern, including 000, is ILLEGAL.
- Phase codes, evaluated in priority order:
  - 5 FAULT: either direction is ILLEGAL.
  - 4 CONFLICT: neither direction is RED.
  - 1 D1_GO: dir2 RED, dir1 not RED.
  - 2 D2_GO: dir1 RED, dir2 not RED.
  - 3 ALL_RED: both RED.
  - 0 IDLE: no vector accepted since reset.
- FSM states:
  - `S_IDLE`: no vector accepted yet. Leaves to `S_TRACK` on the first accepted vector; `phase` updates and no `dur_valid` is issued.
  - `S_TRACK`: the phase counter `pcnt` increments every cycle, saturating at all-ones.
- Phase change in `S_TRACK` (new decoded phase != `phase`):
  - `dur` <= `pcnt`, `dur_valid` = 1 for one cycle.
  - `pcnt` <= 1, `phase` updates.
  - An accepted vector whose phase is unchanged causes no strobe and no counter reset.
- Sticky flags:
  - `conflict` sets while `phase` is 4; `fault` sets while `phase` is 5.
  - `clr_err` clears all three flags. A set condition in the same cycle wins.
- `rst` low at any time: all state returns to reset values immediately, including mid-filter and mid-phase.

## Timing
- Reset values: `phase`=0, `dur`=0, `dur_valid`=0, `conflict`=0, `fault`=0, `stuck`=0, FSM `S_IDLE`, `pcnt`=0, sync chains and `cand`/`acc` = 0.
- Latency: a raw change held steady updates `phase` exactly `SYNC_STAGES`+`STABLE_CYCLES` rising edges after the first edge that samples it. With defaults this is 6 edges.
- `dur_valid` and the flag set are registered in the same cycle as the `phase` update.
- Glitch rule: a raw pulse shorter than `STABLE_CYCLES` cycles after synchronization is never accepted.
- `dur` counts from the cycle `phase` took the old value up to the cycle before the change. A phase held N cycles reports `dur`=N.
- `pcnt` saturates at 2^CNT_W−1 and never wraps.

## Configuration
- `TL_MON_TIMEOUT_EN` defined: `stuck` sets when `pcnt` reaches `MAX_PHASE_CYCLES` in `S_TRACK`, for any phase, and stays set until `clr_err`.
- `TL_MON_TIMEOUT_EN` not defined: the comparator is absent, `stuck` is constant 0 and `MAX_PHASE_CYCLES` is unused.

## Test plan
Bench parameters: `SYNC_STAGES`=2, `STABLE_CYCLES`=4, `CNT_W`=16, `MAX_PHASE_CYCLES`=100.
1. Reset, then drive dir1 001 / dir2 100 steadily → `phase`=1 exactly 6 edges later, no `dur_valid`, all flags 0.
2. From D1_GO held 50 cycles, switch dir1 to 100 → one-cycle `dur_valid` with `dur`=50, `phase`=3.
3. In ALL_RED, pulse `ledg2` high for 3 cycles → `phase` stays 3, no strobe; a 4-cycle pulse (`ledg2`=1 with `ledr2`=1 gives 101, ILLEGAL) → `phase`=5, `fault`=1.
4. Drive dir1 001 and dir2 001 → `phase`=4, `conflict`=1. Return to ALL_RED and pulse `clr_err` → `conflict`=0. Pulse `clr_err` again while `phase`=4 → `conflict` stays 1.
5. With `TL_MON_TIMEOUT_EN` defined, hold ALL_RED 100 cycles → `stuck`=1. Built without the macro → `stuck` stays 0 after 200 cycles.
6. Assert `rst` low mid-phase with `conflict`=1 → all outputs 0 asynchronously. After release, the first accepted vector gives no `dur_valid`.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - lamp-line observer: synchronise, deglitch, decode phase, time it, flag hazards.
// Define TL_MON_TIMEOUT_EN to build the stuck-phase comparator; otherwise stuck is tied low.
module traffic_light_monitor #(
    parameter int              SYNC_STAGES      = 2,
    parameter int              STABLE_CYCLES    = 4,
    parameter int              CNT_W            = 28,
    parameter logic [CNT_W-1:0] MAX_PHASE_CYCLES = 28'd125000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ledr1,
    input  logic             ledb1,
    input  logic             ledg1,
    input  logic             ledr2,
    input  logic             ledb2,
    input  logic             ledg2,
    input  logic             clr_err,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] dur,
    output logic             dur_valid,
    output logic             conflict,
    output logic             fault,
    output logic             stuck
);

    localparam int               STAB_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);

    localparam logic [2:0] PH_D1_GO    = 3'd1;
    localparam logic [2:0] PH_D2_GO    = 3'd2;
    localparam logic [2:0] PH_ALL_RED  = 3'd3;
    localparam logic [2:0] PH_CONFLICT = 3'd4;
    localparam logic [2:0] PH_FAULT    = 3'd5;

    typedef enum logic {S_IDLE, S_TRACK} state_t;

    if (SYNC_STAGES < 2 || STABLE_CYCLES < 1 || MAX_PHASE_CYCLES == '0) begin : g_param_check
        $error("traffic_light_monitor: illegal parameter value");
    end

    function automatic logic [2:0] decode_phase(input logic [5:0] v);
        logic red1, red2, ill1, ill2;
        red1 = (v[5:3] == 3'b100);
        red2 = (v[2:0] == 3'b100);
        ill1 = !(v[5:3] inside {3'b100, 3'b010, 3'b001, 3'b110});
        ill2 = !(v[2:0] inside {3'b100, 3'b010, 3'b001, 3'b110});
        if (ill1 || ill2)       return PH_FAULT;
        else if (!red1 && !red2) return PH_CONFLICT;
        else if (red2 && !red1)  return PH_D1_GO;
        else if (red1 && !red2)  return PH_D2_GO;
        else                     return PH_ALL_RED;
    endfunction

    logic [5:0]        raw;
    logic [5:0]        sync_q [SYNC_STAGES];
    logic [5:0]        s;
    logic [5:0]        cand, acc, acc_next;
    logic [STAB_W-1:0] stab, stab_next;
    logic              accept;
    state_t            state, state_next;
    logic [CNT_W-1:0]  pcnt, pcnt_next, dur_next;
    logic [2:0]        phase_next, new_phase;
    logic              dv_next, conflict_next, fault_next;

    assign raw = {ledr1, ledb1, ledg1, ledr2, ledb2, ledg2};
    assign s   = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= raw;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // acc and phase are loaded on the same edge stab reaches its limit, so decode the incoming value
    always_comb begin
        stab_next = stab;
        if (s != cand)              stab_next = STAB_W'(1);
        else if (stab != STAB_MAX)  stab_next = stab + STAB_W'(1);
        accept    = (stab_next == STAB_MAX);
        acc_next  = accept ? s : acc;
        new_phase = decode_phase(acc_next);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand <= '0;
            stab <= '0;
            acc  <= '0;
        end else begin
            cand <= s;
            stab <= stab_next;
            acc  <= acc_next;
        end
    end

    always_comb begin
        state_next = state;
        phase_next = phase;
        pcnt_next  = pcnt;
        dur_next   = dur;
        dv_next    = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_TRACK;
                    phase_next = new_phase;
                    pcnt_next  = CNT_W'(1);
                end
            end
            S_TRACK: begin
                if (accept && new_phase != phase) begin
                    dur_next   = pcnt;
                    dv_next    = 1'b1;
                    pcnt_next  = CNT_W'(1);
                    phase_next = new_phase;
                end else if (pcnt != '1) begin
                    pcnt_next = pcnt + CNT_W'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase
        conflict_next = (phase_next == PH_CONFLICT) || (conflict && !clr_err);
        fault_next    = (phase_next == PH_FAULT) || (fault && !clr_err);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            phase     <= '0;
            pcnt      <= '0;
            dur       <= '0;
            dur_valid <= 1'b0;
            conflict  <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state     <= state_next;
            phase     <= phase_next;
            pcnt      <= pcnt_next;
            dur       <= dur_next;
            dur_valid <= dv_next;
            conflict  <= conflict_next;
            fault     <= fault_next;
        end
    end

`ifdef TL_MON_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stuck <= 1'b0;
        else      stuck <= (state_next == S_TRACK && pcnt_next >= MAX_PHASE_CYCLES) || (stuck && !clr_err);
    end
`else
    assign stuck = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb/tb_traffic_light_monitor.sv - randomized and directed checks of traffic_light_monitor against a behavioural model.
module tb_traffic_light_monitor;

    localparam int CW = 16;
    localparam int MAXC = 100;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ledr1 = 0, ledb1 = 0, ledg1 = 0, ledr2 = 0, ledb2 = 0, ledg2 = 0;
    logic clr_err = 1'b0;
    logic [2:0]    phase;
    logic [CW-1:0] dur;
    logic          dur_valid, conflict, fault, stuck;

    traffic_light_monitor #(
        .SYNC_STAGES(2), .STABLE_CYCLES(4), .CNT_W(CW), .MAX_PHASE_CYCLES(16'd100)
    ) dut (
        .clk(clk), .rst(rst),
        .ledr1(ledr1), .ledb1(ledb1), .ledg1(ledg1),
        .ledr2(ledr2), .ledb2(ledb2), .ledg2(ledg2),
        .clr_err(clr_err), .phase(phase), .dur(dur), .dur_valid(dur_valid),
        .conflict(conflict), .fault(fault), .stuck(stuck)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int dir_kind(input logic [2:0] rbg);
        case (rbg)
            3'b100:  return 0;
            3'b010:  return 1;
            3'b001:  return 2;
            3'b110:  return 3;
            default: return 4;
        endcase
    endfunction

    function automatic int phase_of(input logic [5:0] v);
        int a, b;
        a = dir_kind(v[5:3]);
        b = dir_kind(v[2:0]);
        if (a == 4 || b == 4) return 5;
        if (a != 0 && b != 0) return 4;
        if (b == 0 && a != 0) return 1;
        if (a == 0 && b != 0) return 2;
        return 3;
    endfunction

    // Reference: a vector is accepted once the raw value seen two edges ago has held for four samples
    logic [5:0] m_hist[$];
    int m_k, m_phase, m_dur, m_held;
    bit m_dv, m_started, m_conf, m_fault, m_stuck;

    task automatic model_reset();
        m_hist = {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
        m_k = 0; m_phase = 0; m_dur = 0; m_held = 0;
        m_dv = 0; m_started = 0; m_conf = 0; m_fault = 0; m_stuck = 0;
    endtask

    task automatic model_step();
        bit acc;
        int np;
        m_k++;
        m_hist.push_back({ledr1, ledb1, ledg1, ledr2, ledb2, ledg2});
        void'(m_hist.pop_front());
        acc = (m_k >= 4) && (m_hist[0] == m_hist[1]) && (m_hist[1] == m_hist[2]) && (m_hist[2] == m_hist[3]);
        np = phase_of(m_hist[3]);
        m_dv = 0;
        if (acc && !m_started) begin
            m_started = 1; m_phase = np; m_held = 1;
        end else if (acc && np != m_phase) begin
            m_dur = m_held; m_dv = 1; m_phase = np; m_held = 1;
        end else if (m_started && m_held < (1 << CW) - 1) begin
            m_held++;
        end
        m_conf  = (m_phase == 4) || (m_conf && !clr_err);
        m_fault = (m_phase == 5) || (m_fault && !clr_err);
`ifdef TL_MON_TIMEOUT_EN
        m_stuck = (m_started && m_held >= MAXC) || (m_stuck && !clr_err);
`endif
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else      model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("phase", phase, m_phase);
            chk("dur_valid", dur_valid, m_dv);
            chk("dur", dur, m_dur);
            chk("conflict", conflict, m_conf);
            chk("fault", fault, m_fault);
            chk("stuck", stuck, m_stuck);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] v);
        {ledr1, ledb1, ledg1, ledr2, ledb2, ledg2} = v;
    endtask

    function automatic logic [2:0] rand_dir();
        logic [2:0] legal [4];
        legal = '{3'b100, 3'b010, 3'b001, 3'b110};
        if ($urandom_range(0, 9) < 8) return legal[$urandom_range(0, 3)];
        return 3'($urandom_range(0, 7));
    endfunction

    initial begin
        logic [5:0] v;
        int hold, g;
        // 1: first acceptance, six edges after sampling
        drive(6'b001_100);
        cyc(3);
        rst = 1'b1;
        cyc(5);
        chk("t1_phase_early", phase, 0);
        cyc(1);
        chk("t1_phase", phase, 1);
        chk("t1_dur_valid", dur_valid, 0);
        chk("t1_flags", {conflict, fault, stuck}, 0);
        // 2: D1_GO held 50 cycles then ALL_RED
        cyc(44);
        drive(6'b100_100);
        cyc(5);
        chk("t2_phase_before", phase, 1);
        cyc(1);
        chk("t2_dur_valid", dur_valid, 1);
        chk("t2_dur", dur, 50);
        chk("t2_phase", phase, 3);
        cyc(1);
        chk("t2_strobe_one_cycle", dur_valid, 0);
        // 3: glitch rejection, then 4-cycle illegal pattern
        cyc(10);
        ledg2 = 1'b1; cyc(3); ledg2 = 1'b0;
        cyc(10);
        chk("t3_glitch_phase", phase, 3);
        ledg2 = 1'b1; cyc(4); ledg2 = 1'b0;
        cyc(2);
        chk("t3_fault_phase", phase, 5);
        chk("t3_fault", fault, 1);
        cyc(4);
        chk("t3_back_phase", phase, 3);
        chk("t3_back_dur", dur, 4);
        chk("t3_fault_sticky", fault, 1);
        // 4: conflict, clear, clear-while-active
        drive(6'b001_001);
        cyc(6);
        chk("t4_phase", phase, 4);
        chk("t4_conflict", conflict, 1);
        drive(6'b100_100);
        cyc(6);
        clr_err = 1'b1; cyc(1); clr_err = 1'b0;
        chk("t4_cleared_conflict", conflict, 0);
        chk("t4_cleared_fault", fault, 0);
        drive(6'b001_001);
        cyc(6);
        clr_err = 1'b1; cyc(1); clr_err = 1'b0;
        chk("t4_set_wins", conflict, 1);
        // 5: long ALL_RED hold
        drive(6'b100_100);
        cyc(6);
        chk("t5_phase", phase, 3);
`ifdef TL_MON_TIMEOUT_EN
        cyc(105);
        chk("t5_stuck", stuck, 1);
`else
        cyc(200);
        chk("t5_stuck_absent", stuck, 0);
`endif
        // 6: asynchronous reset mid-phase
        drive(6'b001_001);
        cyc(6);
        chk("t6_conflict_pre", conflict, 1);
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_outputs", {phase, dur_valid, conflict, fault, stuck}, 0);
        chk("t6_rst_dur", dur, 0);
        drive(6'b100_100);
        cyc(2);
        rst = 1'b1;
        cyc(6);
        chk("t6_first_phase", phase, 3);
        chk("t6_first_no_strobe", dur_valid, 0);
        // randomized phase sequence with glitches and clears
        for (int it = 0; it < 60; it++) begin
            v = {rand_dir(), rand_dir()};
            drive(v);
            hold = $urandom_range(1, 40);
            for (int c = 0; c < hold; c++) begin
                clr_err = ($urandom_range(0, 9) == 0);
                cyc(1);
            end
            clr_err = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                g = $urandom_range(1, 5);
                drive(v ^ (6'd1 << $urandom_range(0, 5)));
                cyc(g);
                drive(v);
                cyc($urandom_range(1, 10));
            end
            if (it == 30) begin
                #2 rst = 1'b0;
                cyc(2);
                rst = 1'b1;
            end
        end
        cyc(10);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
